// File: rtl/bool_pkg.sv
// Shared op encodings and legality check for the boolean pipeline.
// BOOL_POPCNT_EN makes op 0011 (POPCNT) legal.
package bool_pkg;

  typedef enum logic [3:0] {
    OP_PASSA  = 4'b1010,
    OP_AND    = 4'b1000,
    OP_NOR    = 4'b0001,
    OP_OR     = 4'b1110,
    OP_XNOR   = 4'b1001,
    OP_XOR    = 4'b0110,
    OP_POPCNT = 4'b0011
  } bool_op_e;

  function automatic logic is_legal_op(
    input logic [3:0] op
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (op == OP_PASSA): ok = 1'b1;
      (op == OP_AND):   ok = 1'b1;
      (op == OP_NOR):   ok = 1'b1;
      (op == OP_OR):    ok = 1'b1;
      (op == OP_XNOR):  ok = 1'b1;
      (op == OP_XOR):   ok = 1'b1;
`ifdef BOOL_POPCNT_EN
      (op == OP_POPCNT): ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/bool_core.sv
// Combinational op evaluator: result, zero and illegal-op flags.
// BOOL_POPCNT_EN adds the popcount path for op 0011.
module bool_core #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);
  import bool_pkg::*;

`ifdef BOOL_POPCNT_EN
  logic [WIDTH-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++)
      cnt = cnt + {{(WIDTH-1){1'b0}}, a[i]};
  end
`endif

  always_comb begin
    result = '0;
    err    = ~is_legal_op(op);
    unique case (1'b1)
      (op == OP_PASSA): result = a;
      (op == OP_AND):   result = a & b;
      (op == OP_NOR):   result = ~(a | b);
      (op == OP_OR):    result = a | b;
      (op == OP_XNOR):  result = ~(a ^ b);
      (op == OP_XOR):   result = a ^ b;
`ifdef BOOL_POPCNT_EN
      (op == OP_POPCNT): result = cnt;
`endif
      default: result = '0;
    endcase
    zero = ~|result;
  end

endmodule

// File: rtl/bool_pipe.sv
// Two-stage valid/ready boolean unit: S1 holds operands, S2 the result.
// Define BOOL_POPCNT_EN to enable the POPCNT op (0011).
module bool_pipe #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_err
);
  import bool_pkg::*;

  logic             s1_valid;
  logic [OPW-1:0]   s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic [WIDTH-1:0] c_result;
  logic             c_zero;
  logic             c_err;

  logic s2_adv;
  logic in_fire;

  bool_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op    (s1_op),
    .a     (s1_a),
    .b     (s1_b),
    .result(c_result),
    .zero  (c_zero),
    .err   (c_err)
  );

  // S1 may refill whenever S2 can take its current content.
  assign s2_adv   = ~out_valid | out_ready;
  assign in_ready = reset_n & (~s1_valid | ~out_valid | out_ready);
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= c_result;
          out_zero   <= c_zero;
          out_err    <= c_err;
        end
      end
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_op    <= in_op;
        s1_a     <= in_a;
        s1_b     <= in_b;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule
